// File: rtl/id_operand_issue_pkg.sv
// Shared widths and payload layout for the ID operand/issue stage.
// Payload field order toward EX is {pc, inst, src1, src2}.
package id_operand_issue_pkg;

  localparam int ID_DATA_W = 32;
  localparam int ID_RA_W   = 5;

  function automatic int payload_len(input int data_w);
    return 4 * data_w;
  endfunction

  localparam int DS_TO_ES_LEN = payload_len(ID_DATA_W);

endpackage

// File: rtl/id_operand_sel.sv
// Source operand select: a forwarded value from the hazard detector wins over register-file data.
module id_operand_sel #(
  parameter int DATA_W = 32
) (
  input  logic              occur,
  input  logic [DATA_W-1:0] forward,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] operand
);

  assign operand = occur ? forward : rf_rdata;

endmodule

// File: rtl/id_operand_issue.sv
// ID-stage operand/issue register: fetch->ID latch, operand resolution, ID->EX payload handshake.
// Optional stall/back-pressure counters are enabled with the ID_STALL_CNT_EN macro.
module id_operand_issue
  import id_operand_issue_pkg::*;
#(
  parameter int DATA_W = ID_DATA_W,
  parameter int RA_W   = ID_RA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_to_ds_valid,
  input  logic [DATA_W-1:0] fs_pc,
  input  logic [DATA_W-1:0] fs_inst,
  output logic              ds_allowin,
  output logic [DATA_W-1:0] ds_pc,
  output logic [DATA_W-1:0] ds_inst,
  input  logic [RA_W-1:0]   dec_raddr1,
  input  logic [RA_W-1:0]   dec_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              pause,
  input  logic              addr1_occur,
  input  logic              addr2_occur,
  input  logic [DATA_W-1:0] addr1_forward,
  input  logic [DATA_W-1:0] addr2_forward,
  input  logic              flush,
  input  logic              es_allowin,
  output logic              ds_to_es_valid,
  output logic [DATA_W-1:0] es_pc,
  output logic [DATA_W-1:0] es_inst,
  output logic [DATA_W-1:0] es_src1,
  output logic [DATA_W-1:0] es_src2
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bp_cnt
`endif
);

  localparam int PAYLOAD_W = payload_len(DATA_W);

  logic                 ds_valid;
  logic                 ds_ready_go;
  logic                 es_slot_free;
  logic                 ds_to_es_go;
  logic [DATA_W-1:0]    src1;
  logic [DATA_W-1:0]    src2;
  logic [PAYLOAD_W-1:0] es_payload;
  logic                 unused_raddr;

  // Source addresses are consumed by the external hazard detector, not by this stage.
  assign unused_raddr = ^{dec_raddr1, dec_raddr2};

  assign ds_ready_go  = ~pause;
  assign es_slot_free = ~ds_to_es_valid | es_allowin;
  assign ds_allowin   = ~ds_valid | (ds_ready_go & es_slot_free);
  assign ds_to_es_go  = ds_valid & ds_ready_go & es_slot_free;

  id_operand_sel #(.DATA_W(DATA_W)) u_sel1 (
    .occur    (addr1_occur),
    .forward  (addr1_forward),
    .rf_rdata (rf_rdata1),
    .operand  (src1)
  );

  id_operand_sel #(.DATA_W(DATA_W)) u_sel2 (
    .occur    (addr2_occur),
    .forward  (addr2_forward),
    .rf_rdata (rf_rdata2),
    .operand  (src2)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_pc    <= '0;
      ds_inst  <= '0;
    end else begin
      if (flush) begin
        ds_valid <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid <= fs_to_ds_valid;
      end
      if (ds_allowin && fs_to_ds_valid) begin
        ds_pc   <= fs_pc;
        ds_inst <= fs_inst;
      end
    end
  end

  // Operands are captured only on the transfer edge: a stalled forward source may retire meanwhile.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_to_es_valid <= 1'b0;
      es_payload     <= '0;
    end else begin
      if (flush) begin
        ds_to_es_valid <= 1'b0;
      end else if (es_slot_free) begin
        ds_to_es_valid <= ds_valid & ds_ready_go;
      end
      if (ds_to_es_go && !flush) begin
        es_payload <= {ds_pc, ds_inst, src1, src2};
      end
    end
  end

  assign {es_pc, es_inst, es_src1, es_src2} = es_payload;

`ifdef ID_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      bp_cnt    <= '0;
    end else begin
      if (ds_valid && pause && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (ds_to_es_valid && !es_allowin && (bp_cnt != 32'hFFFF_FFFF)) begin
        bp_cnt <= bp_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_operand_issue.sv
// Bench for id_operand_issue: directed scenarios plus randomized traffic against a two-slot
// transaction model (ID slot, EX slot) built from the handshake rules.
module tb_id_operand_issue;
  import id_operand_issue_pkg::*;

  localparam int DW = ID_DATA_W;
  localparam int AW = ID_RA_W;

  logic          clk;
  logic          reset;
  logic          fs_to_ds_valid;
  logic [DW-1:0] fs_pc, fs_inst;
  logic          ds_allowin;
  logic [DW-1:0] ds_pc, ds_inst;
  logic [AW-1:0] dec_raddr1, dec_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          pause, addr1_occur, addr2_occur;
  logic [DW-1:0] addr1_forward, addr2_forward;
  logic          flush, es_allowin;
  logic          ds_to_es_valid;
  logic [DW-1:0] es_pc, es_inst, es_src1, es_src2;
`ifdef ID_STALL_CNT_EN
  logic [31:0]   stall_cnt, bp_cnt;
`endif

  id_operand_issue dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_pc          (fs_pc),
    .fs_inst        (fs_inst),
    .ds_allowin     (ds_allowin),
    .ds_pc          (ds_pc),
    .ds_inst        (ds_inst),
    .dec_raddr1     (dec_raddr1),
    .dec_raddr2     (dec_raddr2),
    .rf_rdata1      (rf_rdata1),
    .rf_rdata2      (rf_rdata2),
    .pause          (pause),
    .addr1_occur    (addr1_occur),
    .addr2_occur    (addr2_occur),
    .addr1_forward  (addr1_forward),
    .addr2_forward  (addr2_forward),
    .flush          (flush),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .es_pc          (es_pc),
    .es_inst        (es_inst),
    .es_src1        (es_src1),
    .es_src2        (es_src2)
`ifdef ID_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .bp_cnt         (bp_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit            v;
    logic [DW-1:0] pc;
    logic [DW-1:0] inst;
    logic [DW-1:0] src1;
    logic [DW-1:0] src2;
  } slot_t;

  slot_t         id_slot, ex_slot;
  int unsigned   exp_stall, exp_bp;
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] next_pc, next_inst;
  logic [DW-1:0] saved_pc;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_allowin();
    return !id_slot.v || (!pause && (!ex_slot.v || es_allowin));
  endfunction

  task automatic model_reset();
    id_slot.v = 0; id_slot.pc = '0; id_slot.inst = '0; id_slot.src1 = '0; id_slot.src2 = '0;
    ex_slot = id_slot;
    exp_stall = 0;
    exp_bp = 0;
  endtask

  // One clock edge of the transaction model, using the inputs currently driven.
  task automatic model_step();
    bit    ex_free, move, accept;
    slot_t nid, nex;
    ex_free = !ex_slot.v || es_allowin;
    move    = id_slot.v && !pause && ex_free;
    accept  = model_allowin();
    if (id_slot.v && pause && exp_stall != 32'hFFFF_FFFF) exp_stall++;
    if (ex_slot.v && !es_allowin && exp_bp != 32'hFFFF_FFFF) exp_bp++;
    nid = id_slot;
    nex = ex_slot;
    if (flush) begin
      nex.v = 0;
      nid.v = 0;
    end else begin
      if (ex_free) begin
        nex.v = move;
        if (move) begin
          nex.pc   = id_slot.pc;
          nex.inst = id_slot.inst;
          nex.src1 = addr1_occur ? addr1_forward : rf_rdata1;
          nex.src2 = addr2_occur ? addr2_forward : rf_rdata2;
        end
      end
      if (accept && fs_to_ds_valid) begin
        nid.v    = 1;
        nid.pc   = fs_pc;
        nid.inst = fs_inst;
      end else if (accept) begin
        nid.v = 0;
      end
    end
    if (fs_to_ds_valid && (accept || flush)) begin
      next_pc   = next_pc + 32'd4;
      next_inst = $urandom;
    end
    id_slot = nid;
    ex_slot = nex;
  endtask

  task automatic checkState();
    checkOutput("ds_to_es_valid", ds_to_es_valid, ex_slot.v);
    if (ex_slot.v) begin
      checkOutput("es_pc", es_pc, ex_slot.pc);
      checkOutput("es_inst", es_inst, ex_slot.inst);
      checkOutput("es_src1", es_src1, ex_slot.src1);
      checkOutput("es_src2", es_src2, ex_slot.src2);
    end
    if (id_slot.v) begin
      checkOutput("ds_pc", ds_pc, id_slot.pc);
      checkOutput("ds_inst", ds_inst, id_slot.inst);
    end
`ifdef ID_STALL_CNT_EN
    checkOutput("stall_cnt", stall_cnt, exp_stall);
    checkOutput("bp_cnt", bp_cnt, exp_bp);
`endif
  endtask

  // Called at a negedge with inputs already driven; runs one clock and checks the result.
  task automatic applyStimulus();
    #1 checkOutput("ds_allowin", ds_allowin, model_allowin());
    model_step();
    @(negedge clk);
    checkState();
  endtask

  task automatic idle_inputs();
    fs_to_ds_valid = 0; fs_pc = next_pc; fs_inst = next_inst;
    dec_raddr1 = '0; dec_raddr2 = '0; rf_rdata1 = '0; rf_rdata2 = '0;
    pause = 0; addr1_occur = 0; addr2_occur = 0; addr1_forward = '0; addr2_forward = '0;
    flush = 0; es_allowin = 1;
  endtask

  task automatic randomize_inputs(input int pause_pct, input int bp_pct, input int flush_pct);
    fs_to_ds_valid = ($urandom_range(99) < 75);
    fs_pc          = next_pc;
    fs_inst        = next_inst;
    dec_raddr1     = AW'($urandom_range(31, 1));
    dec_raddr2     = AW'($urandom_range(31, 0));
    rf_rdata1      = $urandom;
    rf_rdata2      = $urandom;
    addr1_occur    = $urandom_range(1);
    addr2_occur    = $urandom_range(1);
    addr1_forward  = $urandom;
    addr2_forward  = $urandom;
    pause          = ($urandom_range(99) < pause_pct);
    es_allowin     = !($urandom_range(99) < bp_pct);
    flush          = ($urandom_range(99) < flush_pct);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    checkOutput("rst_ds_to_es_valid", ds_to_es_valid, 0);
    checkOutput("rst_ds_allowin", ds_allowin, 1);
    checkOutput("rst_es_pc", es_pc, 0);
    checkOutput("rst_es_inst", es_inst, 0);
    checkOutput("rst_es_src1", es_src1, 0);
    checkOutput("rst_es_src2", es_src2, 0);
    checkOutput("rst_ds_pc", ds_pc, 0);
    checkOutput("rst_ds_inst", ds_inst, 0);
`ifdef ID_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_bp_cnt", bp_cnt, 0);
`endif
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    idle_inputs();
  endtask

  initial begin
    next_pc   = 32'h1c00_0000;
    next_inst = $urandom;
    idle_inputs();
    do_reset();

    // Streaming with no hazards: EX trails ID by exactly one cycle, no gaps.
    for (int i = 1; i <= 6; i++) begin
      idle_inputs();
      fs_to_ds_valid = 1;
      applyStimulus();
      if (i >= 2) begin
        checkOutput("t1_es_pc", es_pc, 32'h1c00_0000 + 32'(4 * (i - 2)));
        checkOutput("t1_valid", ds_to_es_valid, 1);
      end
    end

    // Forwarded src1 overrides RF; src2 comes from RF.
    idle_inputs();
    addr1_occur = 1; addr1_forward = 32'hDEAD_BEEF; rf_rdata1 = 32'h0;
    dec_raddr1 = 5'd3; dec_raddr2 = 5'd4; rf_rdata2 = 32'h1234_5678;
    applyStimulus();
    checkOutput("t2_src1", es_src1, 32'hDEAD_BEEF);
    checkOutput("t2_src2", es_src2, 32'h1234_5678);

    // Two-cycle pause: operand sampled after pause drops.
    idle_inputs();
    saved_pc = next_pc;
    fs_to_ds_valid = 1;
    applyStimulus();
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      fs_to_ds_valid = 1; pause = 1; addr1_occur = 1; addr1_forward = 32'hAA;
      applyStimulus();
      checkOutput("t3_stall_valid", ds_to_es_valid, 0);
      checkOutput("t3_ds_pc_held", ds_pc, saved_pc);
    end
    idle_inputs();
    addr1_occur = 1; addr1_forward = 32'h55;
    applyStimulus();
    checkOutput("t3_src1", es_src1, 32'h55);
    checkOutput("t3_es_pc", es_pc, saved_pc);

    // EX back-pressure for 3 cycles: payload frozen.
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      fs_to_ds_valid = 1; es_allowin = 0;
      applyStimulus();
      checkOutput("t4_es_pc_hold", es_pc, saved_pc);
      checkOutput("t4_valid_hold", ds_to_es_valid, 1);
    end
    idle_inputs();
    fs_to_ds_valid = 1; es_allowin = 0;
    #1 checkOutput("t4_allowin_full", ds_allowin, 0);
    model_step();
    @(negedge clk);
    checkState();

    // Flush dominates pause, fetch and back-pressure.
    idle_inputs();
    fs_to_ds_valid = 1; pause = 1; flush = 1; es_allowin = 0;
    applyStimulus();
    checkOutput("t5_es_valid", ds_to_es_valid, 0);
    idle_inputs();
    applyStimulus();
    checkOutput("t5_es_valid_after", ds_to_es_valid, 0);

`ifdef ID_STALL_CNT_EN
    do_reset();
    idle_inputs();
    fs_to_ds_valid = 1;
    applyStimulus();
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); pause = 1;
      applyStimulus();
    end
    idle_inputs(); es_allowin = 0;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); es_allowin = 0;
      applyStimulus();
    end
    checkOutput("t6_stall_cnt", stall_cnt, 5);
    checkOutput("t6_bp_cnt", bp_cnt, 3);
    idle_inputs();
    applyStimulus();
`endif

    // Randomized traffic with a mid-operation asynchronous reset.
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs(25, 30, 4);
      applyStimulus();
    end
    randomize_inputs(0, 0, 0);
    fs_to_ds_valid = 1;
    @(posedge clk);
    #2;
    model_step();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      applyStimulus();
      checkOutput("post_rst_no_payload", ds_to_es_valid, 0);
    end
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs(20, 20, 2);
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
